// File: rtl/pay_if.sv
// Payment-session bus between the coin/keyboard decoder and the accumulator.
// The decoder side drives requests; the accumulator returns totals and status.
interface pay_if #(
  parameter int AMT_W = 8,
  parameter int KEY_W = 3
);
  logic             enterpay;
  logic [AMT_W-1:0] price;
  logic             coin_valid;
  logic [KEY_W-1:0] coin_code;
  logic             cancel;
  logic [AMT_W-1:0] paid;
  logic [AMT_W-1:0] change;
  logic             busy;
  logic             done;
  logic             refund;
  logic             coin_rej;
  logic [1:0]       state;

  modport master (
    output enterpay, price, coin_valid, coin_code, cancel,
    input  paid, change, busy, done, refund, coin_rej, state
  );

  modport slave (
    input  enterpay, price, coin_valid, coin_code, cancel,
    output paid, change, busy, done, refund, coin_rej, state
  );
endinterface

// File: rtl/pay_accumulator.sv
// Payment-session controller: latches a price, accumulates coins into a running
// total and ends in DONE (with change) or REFUND (cancel, withdrawal, idle timeout).
module pay_accumulator #(
  parameter int AMT_W       = 8,
  parameter int KEY_W       = 3,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input logic  clk,
  input logic  rst,
  pay_if.slave io
);
  localparam int               TMR_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [32:0]      AMT_MAX  = (33'd1 << AMT_W) - 33'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, PAY = 2'd1, DONE = 2'd2, REFUND = 2'd3} state_t;

  // Zero marks an invalid code; wide result so oversized values fail the fit test.
  function automatic logic [32:0] denom(input logic [KEY_W-1:0] code);
    case (32'(code))
      1:       return 33'd1;
      2:       return 33'd2;
      3:       return 33'd5;
      4:       return 33'd10;
      5:       return 33'd20;
      6:       return 33'd50;
      7:       return 33'd100;
      default: return 33'd0;
    endcase
  endfunction

  state_t           st;
  logic [AMT_W-1:0] price_q, paid_q, change_q;
  logic [TMR_W-1:0] timer;
  logic             busy_q, done_q, refund_q, rej_q;

  logic [32:0]      coin_val, sum;
  logic             accept, timeout;
  logic [AMT_W-1:0] paid_nxt;

  always_comb begin
    coin_val = denom(io.coin_code);
    sum      = 33'(paid_q) + coin_val;
    accept   = (st == PAY) && io.coin_valid && (coin_val != 33'd0) && (sum <= AMT_MAX);
    paid_nxt = accept ? sum[AMT_W-1:0] : paid_q;
    timeout  = !accept && (timer >= TMR_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      price_q  <= '0;
      paid_q   <= '0;
      change_q <= '0;
      timer    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      refund_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      refund_q <= 1'b0;
      rej_q    <= io.coin_valid && !accept;
      case (st)
        IDLE: if (io.enterpay) begin
          st       <= PAY;
          busy_q   <= 1'b1;
          price_q  <= io.price;
          paid_q   <= '0;
          change_q <= '0;
          timer    <= '0;
        end
        PAY: begin
          paid_q <= paid_nxt;
          if (accept)                     timer <= '0;
          else if (timer != {TMR_W{1'b1}}) timer <= timer + 1'b1;
          // Abort wins over completion; a coin landing this cycle is still refunded.
          if (io.cancel || !io.enterpay || timeout) begin
            st       <= REFUND;
            busy_q   <= 1'b0;
            change_q <= paid_nxt;
            refund_q <= 1'b1;
          end else if (paid_nxt >= price_q) begin
            st       <= DONE;
            busy_q   <= 1'b0;
            change_q <= paid_nxt - price_q;
            done_q   <= 1'b1;
          end
        end
        DONE, REFUND: if (!io.enterpay) st <= IDLE;
      endcase
    end
  end

  assign io.paid     = paid_q;
  assign io.change   = change_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.refund   = refund_q;
  assign io.coin_rej = rej_q;
  assign io.state    = st;
endmodule

// File: tb/tb_pay_accumulator.sv
// Bench for pay_accumulator: directed vector table, a timeout latency sequence,
// and randomized traffic against a session-level reference model.
module tb_pay_accumulator;
  localparam int AMT_W = 8;
  localparam int KEY_W = 3;
  localparam int TMO   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pay_if #(.AMT_W(AMT_W), .KEY_W(KEY_W)) bus();

  pay_accumulator #(.AMT_W(AMT_W), .KEY_W(KEY_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  typedef struct {
    logic       r, ep;
    logic [7:0] pr;
    logic       cv;
    logic [2:0] code;
    logic       ca;
    int         st, paid, chg;
    logic       dn, rf, rj;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  int denom[8] = '{0, 1, 2, 5, 10, 20, 50, 100};
  int m_st, m_price, m_paid, m_chg, m_last, cyc;
  bit m_dn, m_rf, m_rj;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input int st, input int paid, input int chg,
                     input bit dn, input bit rf, input bit rj);
    chk({tag, " state"},    32'(bus.state),    st);
    chk({tag, " paid"},     32'(bus.paid),     paid);
    chk({tag, " change"},   32'(bus.change),   chg);
    chk({tag, " busy"},     32'(bus.busy),     (st == 1) ? 1 : 0);
    chk({tag, " done"},     32'(bus.done),     int'(dn));
    chk({tag, " refund"},   32'(bus.refund),   int'(rf));
    chk({tag, " coin_rej"}, 32'(bus.coin_rej), int'(rj));
  endtask

  task automatic drive(input logic r, input logic ep, input logic [7:0] pr,
                       input logic cv, input logic [2:0] code, input logic ca);
    rst            = r;
    bus.enterpay   = ep;
    bus.price      = pr;
    bus.coin_valid = cv;
    bus.coin_code  = code;
    bus.cancel     = ca;
    @(posedge clk);
    #1;
  endtask

  function automatic void row(input logic r, input logic ep, input logic [7:0] pr,
                              input logic cv, input logic [2:0] code, input logic ca,
                              input int st, input int paid, input int chg,
                              input logic dn, input logic rf, input logic rj);
    vec_t v;
    v.r = r; v.ep = ep; v.pr = pr; v.cv = cv; v.code = code; v.ca = ca;
    v.st = st; v.paid = paid; v.chg = chg; v.dn = dn; v.rf = rf; v.rj = rj;
    tbl.push_back(v);
  endfunction

  // Session-level reference: a timeout is "TMO edges since the last coin or session start".
  task automatic model(input bit r, input bit ep, input int pr, input bit cv,
                       input int code, input bit ca);
    int v;
    bit acc;
    cyc++;
    m_dn = 0; m_rf = 0; m_rj = 0;
    if (r) begin
      m_st = 0; m_price = 0; m_paid = 0; m_chg = 0;
      return;
    end
    v    = denom[code];
    acc  = (m_st == 1) && cv && (v != 0) && (m_paid + v <= 255);
    m_rj = cv && !acc;
    case (m_st)
      0: if (ep) begin
        m_st = 1; m_price = pr; m_paid = 0; m_chg = 0; m_last = cyc;
      end
      1: begin
        if (acc) begin m_paid += v; m_last = cyc; end
        if (ca || !ep || (cyc - m_last >= TMO)) begin
          m_st = 3; m_chg = m_paid; m_rf = 1;
        end else if (m_paid >= m_price) begin
          m_st = 2; m_chg = m_paid - m_price; m_dn = 1;
        end
      end
      default: if (!ep) m_st = 0;
    endcase
  endtask

  initial begin
    int n;
    bit ep_r;
    int cv_pct;

    // Reset
    row(1, 0, 0,   0, 0, 0,  0, 0,   0,   0, 0, 0);
    // price 15: 10 then 5 -> DONE, change 0
    row(0, 1, 15,  0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 0,   1, 4, 0,  1, 10,  0,   0, 0, 0);
    row(0, 1, 0,   1, 3, 0,  2, 15,  0,   1, 0, 0);
    row(0, 1, 0,   0, 0, 0,  2, 15,  0,   0, 0, 0);
    row(0, 0, 0,   0, 0, 0,  0, 15,  0,   0, 0, 0);
    // price 12: single 20 -> change 8
    row(0, 1, 12,  0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 12,  1, 5, 0,  2, 20,  8,   1, 0, 0);
    row(0, 0, 0,   0, 0, 0,  0, 20,  8,   0, 0, 0);
    // price 255: five 50s, sixth overflows, then 5 completes exactly
    row(0, 1, 255, 0, 0, 0,  1, 0,   0,   0, 0, 0);
    for (int k = 1; k <= 5; k++) row(0, 1, 255, 1, 6, 0, 1, 50 * k, 0, 0, 0, 0);
    row(0, 1, 255, 1, 6, 0,  1, 250, 0,   0, 0, 1);
    row(0, 1, 255, 1, 3, 0,  2, 255, 0,   1, 0, 0);
    row(0, 1, 0,   1, 1, 1,  2, 255, 0,   0, 0, 1);
    row(0, 0, 0,   0, 0, 0,  0, 255, 0,   0, 0, 0);
    // price 50: 10, then cancel with a 2 in the same cycle -> refund 12
    row(0, 1, 50,  0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 50,  1, 4, 0,  1, 10,  0,   0, 0, 0);
    row(0, 1, 50,  1, 2, 1,  3, 12,  12,  0, 1, 0);
    row(0, 1, 50,  0, 0, 0,  3, 12,  12,  0, 0, 0);
    row(0, 0, 0,   0, 0, 0,  0, 12,  12,  0, 0, 0);
    // price 30: one 10 then idle -> refund exactly TMO edges later
    row(0, 1, 30,  0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 30,  1, 4, 0,  1, 10,  0,   0, 0, 0);
    for (int k = 1; k < TMO; k++) row(0, 1, 30, 0, 0, 0, 1, 10, 0, 0, 0, 0);
    row(0, 1, 30,  0, 0, 0,  3, 10,  10,  0, 1, 0);
    row(0, 0, 0,   0, 0, 0,  0, 10,  10,  0, 0, 0);
    // invalid code, reach 7, reset mid-session, then a price-0 session
    row(0, 1, 20,  0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 20,  1, 0, 0,  1, 0,   0,   0, 0, 1);
    row(0, 1, 20,  1, 3, 0,  1, 5,   0,   0, 0, 0);
    row(0, 1, 20,  1, 2, 0,  1, 7,   0,   0, 0, 0);
    row(1, 1, 20,  1, 1, 0,  0, 0,   0,   0, 0, 0);
    row(0, 1, 0,   0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 0,   0, 0, 0,  2, 0,   0,   1, 0, 0);
    row(0, 0, 0,   1, 1, 0,  0, 0,   0,   0, 0, 1);
    row(0, 0, 0,   1, 7, 0,  0, 0,   0,   0, 0, 1);
    // withdrawal of enterpay mid-PAY -> refund
    row(0, 1, 200, 0, 0, 0,  1, 0,   0,   0, 0, 0);
    row(0, 1, 200, 1, 7, 0,  1, 100, 0,   0, 0, 0);
    row(0, 0, 200, 0, 0, 0,  3, 100, 100, 0, 1, 0);
    row(0, 0, 0,   0, 0, 0,  0, 100, 100, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ep, tbl[i].pr, tbl[i].cv, tbl[i].code, tbl[i].ca);
      cmp($sformatf("row%0d", i), tbl[i].st, tbl[i].paid, tbl[i].chg,
          tbl[i].dn, tbl[i].rf, tbl[i].rj);
    end

    // No coin at all: refund TMO edges after the session starts
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 200, 0, 0, 0);
    chk("tmo start state", 32'(bus.state), 1);
    n = 0;
    while (bus.state == 2'd1 && n < 5 * TMO) begin
      drive(0, 1, 200, 0, 0, 0);
      n++;
    end
    chk("tmo latency", 32'(n), TMO);
    chk("tmo refund", 32'(bus.refund), 1);
    chk("tmo change", 32'(bus.change), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("tmo idle", 32'(bus.state), 0);

    // Randomized traffic against the reference model
    cyc = 0;
    drive(1, 0, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0, 0);
    ep_r   = 0;
    cv_pct = 40;
    for (int i = 0; i < 4000; i++) begin
      logic       r, cv, ca;
      logic [7:0] pr;
      logic [2:0] code;
      if (i % 200 == 0) cv_pct = (i % 600 == 0) ? 5 : ((i % 600 == 200) ? 40 : 80);
      if ($urandom_range(0, 24) == 0) ep_r = !ep_r;
      r    = ($urandom_range(0, 299) == 0);
      cv   = ($urandom_range(0, 99) < cv_pct);
      code = 3'($urandom_range(0, 7));
      ca   = ($urandom_range(0, 59) == 0);
      pr   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      drive(r, ep_r, pr, cv, code, ca);
      model(r, ep_r, int'(pr), cv, int'(code), ca);
      cmp($sformatf("rnd%0d", i), m_st, m_paid, m_chg, m_dn, m_rf, m_rj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
